// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first frame with optional parity.
// Outputs the received word with a one-clock rx_done strobe and error flags.
module uart_rx #(
   parameter int unsigned BAUD              = 9600,
   parameter int unsigned clk_freq          = 50_000_000,
   parameter int unsigned oversampling_rate = 16,
   parameter int unsigned data_wd           = 8,
   parameter int unsigned parity            = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               rx,
   output logic [data_wd-1:0] dout,
   output logic               rx_done,
   output logic               rx_busy,
   output logic               parity_err,
   output logic               frame_err
);

   localparam int CW = $clog2(oversampling_rate);
   localparam int IW = $clog2(data_wd) + 1;
   localparam logic [CW-1:0] mid_cnt  = CW'(oversampling_rate / 2 - 1);
   localparam logic [CW-1:0] last_cnt = CW'(oversampling_rate - 1);
   localparam logic [IW-1:0] last_bit = IW'(data_wd - 1);
   localparam bit has_parity = (parity == 1) || (parity == 2);

   // BAUD and clk_freq only matter to the tick generator; reject impossible pairs early.
   if (clk_freq < BAUD * oversampling_rate) begin : g_rate_check
      $error("uart_rx: clk_freq cannot supply BAUD * oversampling_rate ticks");
   end

   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      DONE   = 6'b100000
   } state_t;

   state_t             state_reg;
   logic [1:0]         rx_sync_reg;
   logic [CW-1:0]      tick_count_reg;
   logic [IW-1:0]      bit_index_reg;
   logic [data_wd-1:0] shift_reg;
   logic [data_wd-1:0] dout_reg;
   logic               rx_done_reg;
   logic               parity_err_reg;
   logic               frame_err_reg;
   logic               rx_s;
   logic               exp_parity;

   assign rx_s = rx_sync_reg[1];

   always_comb begin
      exp_parity = (parity == 1) ? ~^shift_reg : ^shift_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         rx_sync_reg    <= 2'b11;
         tick_count_reg <= '0;
         bit_index_reg  <= '0;
         shift_reg      <= '0;
         dout_reg       <= '0;
         rx_done_reg    <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         rx_sync_reg <= {rx_sync_reg[0], rx};
         rx_done_reg <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_reg      <= START;
                  tick_count_reg <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (tick_count_reg == mid_cnt) begin
                     tick_count_reg <= '0;
                     if (!rx_s) begin
                        state_reg      <= DATA;
                        bit_index_reg  <= '0;
                        parity_err_reg <= 1'b0;
                        frame_err_reg  <= 1'b0;
                     end else begin
                        state_reg <= IDLE;
                     end
                  end else begin
                     tick_count_reg <= tick_count_reg + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tick_count_reg == last_cnt) begin
                     tick_count_reg <= '0;
                     // Shift in from the top so the first (LSB) bit ends up at bit 0.
                     shift_reg <= (shift_reg >> 1) |
                                  ({{(data_wd-1){1'b0}}, rx_s} << (data_wd - 1));
                     if (bit_index_reg == last_bit) begin
                        state_reg <= has_parity ? PARITY : STOP;
                     end else begin
                        bit_index_reg <= bit_index_reg + 1'b1;
                     end
                  end else begin
                     tick_count_reg <= tick_count_reg + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  if (tick_count_reg == last_cnt) begin
                     tick_count_reg <= '0;
                     parity_err_reg <= (rx_s != exp_parity);
                     state_reg      <= STOP;
                  end else begin
                     tick_count_reg <= tick_count_reg + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (tick_count_reg == last_cnt) begin
                     tick_count_reg <= '0;
                     frame_err_reg  <= ~rx_s;
                     state_reg      <= DONE;
                  end else begin
                     tick_count_reg <= tick_count_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               dout_reg    <= shift_reg;
               rx_done_reg <= 1'b1;
               state_reg   <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // IDLE is bit 0 of the one-hot state, so busy comes straight from a flop.
   assign rx_busy    = ~state_reg[0];
   assign dout       = dout_reg;
   assign rx_done    = rx_done_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-level serial driver with a 1-in-4 clock tick,
// so one bit lasts 16 ticks = 64 clocks.
module tb_uart_rx;

   localparam int CLKS_PER_BIT = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       rx_done;
   logic       rx_busy;
   logic       parity_err;
   logic       frame_err;

   int         n_checks = 0;
   int         n_pass = 0;
   int         done_count = 0;
   logic [7:0] cap_dout[$];
   logic       cap_perr = 1'b0;
   logic       cap_ferr = 1'b0;

   uart_rx #(
      .BAUD(9600),
      .clk_freq(50_000_000),
      .oversampling_rate(16),
      .data_wd(8),
      .parity(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .rx(rx),
      .dout(dout),
      .rx_done(rx_done),
      .rx_busy(rx_busy),
      .parity_err(parity_err),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin : tick_gen
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         tick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         done_count = done_count + 1;
         cap_dout.push_back(dout);
         cap_perr = parity_err;
         cap_ferr = frame_err;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      idle(CLKS_PER_BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      $display("frame data=%02h parity_bit=%0d stop_bit=%0d", d, p, s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      rx = 1'b1;
   endtask

   logic [7:0] b2b_data [5] = '{8'h3C, 8'hA5, 8'h01, 8'h80, 8'h7E};
   logic       b2b_par  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   int         base;

   initial begin
      // 1: reset
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_rx_done", 32'(rx_done), 32'h0);
      check("rst_rx_busy", 32'(rx_busy), 32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      rst = 1'b1;
      idle(20);

      // 2: single clean frame, 8'hD3 has five ones -> odd parity bit 0
      base = done_count;
      cap_dout.delete();
      send_frame(8'hD3, 1'b0, 1'b1);
      idle(CLKS_PER_BIT);
      check("d3_pulses", 32'(done_count - base), 32'd1);
      check("d3_dout", 32'(dout), 32'hD3);
      check("d3_parity_err", 32'(cap_perr), 32'h0);
      check("d3_frame_err", 32'(cap_ferr), 32'h0);
      check("d3_busy_after", 32'(rx_busy), 32'h0);

      // 3: back-to-back frames, no idle gap
      base = done_count;
      cap_dout.delete();
      for (int i = 0; i < 5; i++) send_frame(b2b_data[i], b2b_par[i], 1'b1);
      idle(CLKS_PER_BIT);
      check("b2b_pulses", 32'(done_count - base), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < cap_dout.size()) check($sformatf("b2b_dout%0d", i), 32'(cap_dout[i]), 32'(b2b_data[i]));
         else check($sformatf("b2b_missing%0d", i), 32'(cap_dout.size()), 32'(i + 1));
      end
      check("b2b_parity_err", 32'(cap_perr), 32'h0);

      // 4: 4-tick low glitch is a false start
      base = done_count;
      $display("glitch low 16 clocks");
      rx = 1'b0;
      idle(8);
      check("glitch_busy", 32'(rx_busy), 32'h1);
      idle(8);
      rx = 1'b1;
      idle(48);
      check("glitch_idle", 32'(rx_busy), 32'h0);
      check("glitch_no_done", 32'(done_count - base), 32'd0);

      // 5: parity error on 8'h00 (odd needs 1), then framing error on 8'hFF
      cap_dout.delete();
      send_frame(8'h00, 1'b0, 1'b1);
      idle(CLKS_PER_BIT);
      check("perr_flag", 32'(cap_perr), 32'h1);
      check("perr_no_ferr", 32'(cap_ferr), 32'h0);
      check("perr_dout", 32'(dout), 32'h00);
      send_frame(8'hFF, 1'b1, 1'b0);
      check("ferr_flag", 32'(cap_ferr), 32'h1);
      check("ferr_no_perr", 32'(cap_perr), 32'h0);
      check("ferr_dout", 32'(cap_dout[cap_dout.size()-1]), 32'hFF);
      idle(20 * CLKS_PER_BIT);

      // 6: reset after four data bits of 8'hD3 (1,1,0,0 LSB first)
      $display("partial frame d3, reset after 4 data bits");
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      check("mid_busy", 32'(rx_busy), 32'h1);
      base = done_count;
      rst = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_done", 32'(rx_done), 32'h0);
      check("mid_rst_busy", 32'(rx_busy), 32'h0);
      check("mid_rst_perr", 32'(parity_err), 32'h0);
      check("mid_rst_ferr", 32'(frame_err), 32'h0);
      rst = 1'b1;
      idle(100);
      check("mid_rst_no_done", 32'(done_count - base), 32'd0);
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(CLKS_PER_BIT);
      check("after_rst_pulses", 32'(done_count - base), 32'd1);
      check("after_rst_dout", 32'(dout), 32'h5A);
      check("after_rst_perr", 32'(parity_err), 32'h0);
      check("after_rst_ferr", 32'(frame_err), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
